// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with first-word-fall-through receive FIFO and valid/ready drain.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUDRATE   = 25000000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    input  logic                          overflow_clr
);
    localparam int CPB    = CLK_HZ / BAUDRATE;
    localparam int HALF   = CPB / 2;
    localparam int CNT_W  = $clog2(CPB);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CPB_M1 = CPB - 1;
    localparam int HALF_M1 = HALF - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CPB_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_HALF = HALF_M1[CNT_W-1:0];
    localparam logic [AW:0]      LVL_FULL = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_sync_p0, rx_s, rx_s_p1;
    logic             par_ok;
    logic             sample, push, pop, full, wr_en;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

`ifdef UART_RX_PARITY_EN
    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Synchronizer: idle-high reset value keeps a reset release from looking like a start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_s       <= 1'b1;
            rx_s_p1    <= 1'b1;
        end else begin
            rx_sync_p0 <= uart_rx;
            rx_s       <= rx_sync_p0;
            rx_s_p1    <= rx_s;
        end
    end

    assign sample = (cnt == CNT_LAST);
    assign push   = (state == STOP) && sample && rx_s && par_ok;
    assign pop    = rx_valid && rx_ready;
    assign full   = (rx_level == LVL_FULL);
    assign wr_en  = push && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok     <= 1'b1;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: if (rx_s_p1 && !rx_s) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (cnt == CNT_HALF) begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DATA: if (sample) begin
                    cnt     <= '0;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (sample) begin
                    cnt        <= '0;
                    par_ok     <= (rx_s == even_par(shreg));
                    parity_err <= (rx_s != even_par(shreg));
                    state      <= STOP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                STOP: if (sample) begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && sample) shreg <= {rx_s, shreg[7:1]};
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    // FIFO control: a push into a full FIFO is accepted only when a pop frees the slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_level <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            rx_level <= rx_level + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};
            if (push && full && !pop) overflow <= 1'b1;
            else if (overflow_clr)    overflow <= 1'b0;
        end
    end

    assign rx_valid = (rx_level != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: CPB=2/depth-4 instance and CPB=50 instance, scoreboarded.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int CPB_A = 2;
    localparam int CPB_B = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rx_a, ready_a, clr_a;
    logic [7:0] data_a;
    logic       valid_a, ferr_a, perr_a, ovf_a;
    logic [2:0] level_a;
    logic       rx_b, ready_b, clr_b;
    logic [7:0] data_b;
    logic       valid_b, ferr_b, perr_b, ovf_b;
    logic [4:0] level_b;

    uart_rx_fifo #(.FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .uart_rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .rx_level(level_a), .frame_err(ferr_a), .parity_err(perr_a),
        .overflow(ovf_a), .overflow_clr(clr_a));

    uart_rx_fifo #(.BAUDRATE(1000000)) dut_b (
        .clk(clk), .reset(reset), .uart_rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .rx_level(level_b), .frame_err(ferr_b), .parity_err(perr_b),
        .overflow(ovf_b), .overflow_clr(clr_b));

    int n_total = 0, n_pass = 0, n_fail = 0;
    int beats_a = 0, ferr_cnt_a = 0, perr_cnt_a = 0;
    int beats_b = 0, ferr_cnt_b = 0, perr_cnt_b = 0;
    int b0, f0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Output monitors: every accepted beat is matched against the scoreboard head
    always @(negedge clk) begin
        if (!reset) begin
            if (valid_a && ready_a) begin
                beats_a++;
                check("a_sb_pending", 32'(exp_a.size() != 0), 1);
                if (exp_a.size() != 0) check("a_rx_data", {24'h0, data_a}, {24'h0, exp_a.pop_front()});
            end
            if (valid_b && ready_b) begin
                beats_b++;
                check("b_sb_pending", 32'(exp_b.size() != 0), 1);
                if (exp_b.size() != 0) check("b_rx_data", {24'h0, data_b}, {24'h0, exp_b.pop_front()});
            end
            if (ferr_a) ferr_cnt_a++;
            if (perr_a) perr_cnt_a++;
            if (ferr_b) ferr_cnt_b++;
            if (perr_b) perr_cnt_b++;
        end
    end

    task automatic line_a(input logic v, input int n);
        rx_a = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic line_b(input logic v, input int n);
        rx_b = v;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_a(input logic [7:0] b, input logic stop_v, input logic keep);
        if (keep) exp_a.push_back(b);
        line_a(1'b0, CPB_A);
        for (int i = 0; i < 8; i++) line_a(b[i], CPB_A);
`ifdef UART_RX_PARITY_EN
        line_a(^b, CPB_A);
`endif
        line_a(stop_v, CPB_A);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par_a(input logic [7:0] b, input logic pbit, input logic keep);
        if (keep) exp_a.push_back(b);
        line_a(1'b0, CPB_A);
        for (int i = 0; i < 8; i++) line_a(b[i], CPB_A);
        line_a(pbit, CPB_A);
        line_a(1'b1, CPB_A);
    endtask
`endif

    task automatic send_b(input logic [7:0] b);
        exp_b.push_back(b);
        line_b(1'b0, CPB_B);
        for (int i = 0; i < 8; i++) line_b(b[i], CPB_B);
`ifdef UART_RX_PARITY_EN
        line_b(^b, CPB_B);
`endif
        line_b(1'b1, CPB_B);
    endtask

    initial begin
        reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_a), 0);
        check("rst_data", 32'(data_a), 0);
        check("rst_level", 32'(level_a), 0);
        check("rst_ferr", 32'(ferr_a), 0);
        check("rst_perr", 32'(perr_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        reset = 1'b0;
        line_a(1'b1, 5);

        // Back-to-back frames drained immediately
        send_a(8'h55, 1'b1, 1'b1);
        send_a(8'hA3, 1'b1, 1'b1);
        line_a(1'b1, 10);
        check("t1_beats", 32'(beats_a), 2);
        check("t1_sb_empty", 32'(exp_a.size()), 0);
        check("t1_ferr", 32'(ferr_cnt_a), 0);

        // Fill, push-while-full-with-pop, overflow, drain, clear
        ready_a = 1'b0;
        send_a(8'h01, 1'b1, 1'b1);
        line_a(1'b1, 1);
        check("t2_lat_early", 32'(level_a), 0);
        line_a(1'b1, 1);
        check("t2_lat_level", 32'(level_a), 1);
        check("t2_lat_data", 32'(data_a), 32'h01);
        send_a(8'h02, 1'b1, 1'b1);
        send_a(8'h03, 1'b1, 1'b1);
        send_a(8'h04, 1'b1, 1'b1);
        line_a(1'b1, 4);
        check("t2_full_level", 32'(level_a), 4);
        check("t2_full_ovf", 32'(ovf_a), 0);
        send_a(8'h05, 1'b1, 1'b1);
        line_a(1'b1, 1);
        ready_a = 1'b1;
        line_a(1'b1, 1);
        ready_a = 1'b0;
        line_a(1'b1, 4);
        check("t2_pushpop_level", 32'(level_a), 4);
        check("t2_pushpop_ovf", 32'(ovf_a), 0);
        send_a(8'h06, 1'b1, 1'b0);
        line_a(1'b1, 6);
        check("t2_ovf_level", 32'(level_a), 4);
        check("t2_ovf_set", 32'(ovf_a), 1);
        check("t2_ovf_head", 32'(data_a), 32'h02);
        ready_a = 1'b1;
        line_a(1'b1, 8);
        check("t2_drained_sb", 32'(exp_a.size()), 0);
        check("t2_drained_level", 32'(level_a), 0);
        check("t2_beats", 32'(beats_a), 7);
        check("t2_ovf_sticky", 32'(ovf_a), 1);
        clr_a = 1'b1;
        line_a(1'b1, 1);
        clr_a = 1'b0;
        check("t2_ovf_clr", 32'(ovf_a), 0);

        // Stop bit low -> one frame error, then clean recovery
        b0 = beats_a; f0 = ferr_cnt_a;
        send_a(8'h7E, 1'b0, 1'b0);
        line_a(1'b1, 10);
        check("t3_ferr_once", 32'(ferr_cnt_a), 32'(f0 + 1));
        check("t3_level", 32'(level_a), 0);
        check("t3_no_beat", 32'(beats_a), 32'(b0));
        send_a(8'h42, 1'b1, 1'b1);
        line_a(1'b1, 8);
        check("t3_recover_beat", 32'(beats_a), 32'(b0 + 1));
        check("t3_sb_empty", 32'(exp_a.size()), 0);

        // Slow line: 1-cycle glitch, held-low break, recovery
        line_b(1'b0, 1);
        line_b(1'b1, 200);
        check("t4_glitch_beats", 32'(beats_b), 0);
        check("t4_glitch_ferr", 32'(ferr_cnt_b), 0);
        line_b(1'b0, 700);
        line_b(1'b1, 100);
        check("t4_break_ferr", 32'(ferr_cnt_b), 1);
        check("t4_break_beats", 32'(beats_b), 0);
        check("t4_break_level", 32'(level_b), 0);
        send_b(8'h5A);
        line_b(1'b1, 40);
        check("t4_recover_beats", 32'(beats_b), 1);
        check("t4_sb_empty", 32'(exp_b.size()), 0);

        // Reset in the middle of a frame with a byte parked in the FIFO
        ready_a = 1'b0;
        send_a(8'h11, 1'b1, 1'b1);
        line_a(1'b1, 4);
        check("t5_parked", 32'(level_a), 1);
        line_a(1'b0, CPB_A);
        line_a(1'b1, CPB_A);
        line_a(1'b1, CPB_A);
        line_a(1'b0, CPB_A);
        reset = 1'b1;
        #2;
        check("t5_valid", 32'(valid_a), 0);
        check("t5_data", 32'(data_a), 0);
        check("t5_level", 32'(level_a), 0);
        check("t5_ferr", 32'(ferr_a), 0);
        check("t5_perr", 32'(perr_a), 0);
        check("t5_ovf", 32'(ovf_a), 0);
        exp_a.delete();
        rx_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        line_a(1'b1, 5);
        ready_a = 1'b1;
        b0 = beats_a;
        send_a(8'h3C, 1'b1, 1'b1);
        line_a(1'b1, 8);
        check("t5_after_beat", 32'(beats_a), 32'(b0 + 1));
        check("t5_sb_empty", 32'(exp_a.size()), 0);

`ifdef UART_RX_PARITY_EN
        b0 = beats_a; f0 = perr_cnt_a;
        send_par_a(8'h07, 1'b1, 1'b1);
        send_par_a(8'h07, 1'b0, 1'b0);
        line_a(1'b1, 8);
        check("t6_beats", 32'(beats_a), 32'(b0 + 1));
        check("t6_perr_once", 32'(perr_cnt_a), 32'(f0 + 1));
        check("t6_level", 32'(level_a), 0);
        check("t6_sb_empty", 32'(exp_a.size()), 0);
`else
        check("t6_perr_none", 32'(perr_cnt_a), 0);
`endif
        check("end_ferr_a", 32'(ferr_cnt_a), 1);
        check("end_perr_b", 32'(perr_cnt_b), 0);
        check("end_ovf_b", 32'(ovf_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
